// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per cycle, LSB digit first,
// and publishes the full WIDTH-bit result, carry and signed overflow on the
// cycle it completes. Results hold until the next completion.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;   // b_reg already inverted for subtract
  logic [WIDTH-1:0] acc, acc_nxt;   // partial result, never visible on sum
  logic             carry;
  logic [CW-1:0]    k;
  logic [DIGIT:0]   dsum;
  logic             last;
  logic             load;

  assign last = (k == CW'(NDIG - 1));
  // DONE accepts a new start just like IDLE, giving back-to-back operation.
  assign load = start && (state != RUN);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // One digit of the ripple: current digit pair plus the carry register.
  always_comb begin
    dsum    = {1'b0, a_reg[int'(k)*DIGIT +: DIGIT]}
            + {1'b0, b_reg[int'(k)*DIGIT +: DIGIT]}
            + {{DIGIT{1'b0}}, carry};
    acc_nxt = acc;
    acc_nxt[int'(k)*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, digit iteration and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      k     <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      carry <= dsum[DIGIT];
      k     <= last ? '0 : k + CW'(1);
      if (last) begin
        sum  <= acc_nxt;
        cout <= dsum[DIGIT];
        // Carry into the MSB is a^b^s at that bit; overflow is it XOR carry out.
        ovf  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ acc_nxt[WIDTH-1] ^ dsum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        cin8, sub8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // Issue one operation at the current negedge (cycle 0) and advance until
  // done is seen; lat is the cycle number of done, nbusy counts busy cycles.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic is,
                       output int lat, output int nbusy);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) nbusy++;
    end while (!done && lat < 40);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, cout, ovf} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy, done, cout, ovf}); else pass++;
    total++; if (sum !== 32'h0) $display("FAIL reset_sum got %h want 00000000", sum); else pass++;
    total++; if ({busy8, done8, cout8, ovf8, sum8} !== 12'h0) $display("FAIL reset_dut8 got %h want 000", {busy8, done8, cout8, ovf8, sum8}); else pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_wrap();
    int lat, nb;
    do_op(32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, lat, nb);
    total++; if (lat !== 9) $display("FAIL wrap_latency got %0d want 9", lat); else pass++;
    total++; if (nb !== 8) $display("FAIL wrap_busy_cycles got %0d want 8", nb); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL wrap_busy_at_done got %b want 0", busy); else pass++;
    total++; if ({sum, cout, ovf} !== {32'h0, 1'b1, 1'b0}) $display("FAIL wrap_result got %h/%b/%b want 00000000/1/0", sum, cout, ovf); else pass++;
    @(negedge clk);
    total++; if ({done, sum, cout} !== {1'b0, 32'h0, 1'b1}) $display("FAIL wrap_hold got %b/%h/%b want 0/00000000/1", done, sum, cout); else pass++;
  endtask

  task automatic test_overflow();
    int lat, nb;
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, nb);
    total++; if ({sum, cout, ovf} !== {32'h80000000, 1'b0, 1'b1}) $display("FAIL ovf_pos got %h/%b/%b want 80000000/0/1", sum, cout, ovf); else pass++;
    @(negedge clk);
    do_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, lat, nb);
    total++; if ({sum, cout, ovf} !== {32'hACF13569, 1'b0, 1'b0}) $display("FAIL add_cin got %h/%b/%b want ACF13569/0/0", sum, cout, ovf); else pass++;
    @(negedge clk);
    do_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, lat, nb);
    total++; if ({sum, cout, ovf} !== {32'h0, 1'b1, 1'b1}) $display("FAIL ovf_neg got %h/%b/%b want 00000000/1/1", sum, cout, ovf); else pass++;
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat, nb;
    do_op(32'd5, 32'd7, 1'b1, 1'b1, lat, nb);
    total++; if ({sum, cout, ovf} !== {32'hFFFFFFFE, 1'b0, 1'b0}) $display("FAIL sub_5_7 got %h/%b/%b want FFFFFFFE/0/0", sum, cout, ovf); else pass++;
    @(negedge clk);
    do_op(32'd7, 32'd5, 1'b0, 1'b1, lat, nb);
    total++; if ({sum, cout, ovf} !== {32'h2, 1'b1, 1'b0}) $display("FAIL sub_7_5 got %h/%b/%b want 00000002/1/0", sum, cout, ovf); else pass++;
    @(negedge clk);
    do_op(32'h80000000, 32'd1, 1'b0, 1'b1, lat, nb);
    total++; if ({sum, cout, ovf} !== {32'h7FFFFFFF, 1'b1, 1'b1}) $display("FAIL sub_ovf got %h/%b/%b want 7FFFFFFF/1/1", sum, cout, ovf); else pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    a = 32'h10; b = 32'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;                 // cycle 1
    @(negedge clk);                               // cycle 2
    @(negedge clk);                               // cycle 3: ignored start
    a = 32'h1000; b = 32'h1000; sub = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;                 // cycle 4
    cyc = 4;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    total++; if (cyc !== 9) $display("FAIL b2b_first_latency got %0d want 9", cyc); else pass++;
    total++; if ({sum, cout} !== {32'h30, 1'b0}) $display("FAIL b2b_first_result got %h/%b want 00000030/0", sum, cout); else pass++;
    // start during the done cycle is accepted
    a = 32'h100; b = 32'h200; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_restart got %b want 10", {busy, done}); else pass++;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    total++; if (cyc !== 9) $display("FAIL b2b_second_latency got %0d want 9", cyc); else pass++;
    total++; if (sum !== 32'h300) $display("FAIL b2b_second_result got %h want 00000300", sum); else pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, nb, seen;
    do_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, lat, nb);  // leaves sum=0, cout=1, ovf=1
    @(negedge clk);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, nb);  // leaves sum nonzero, ovf=1
    @(negedge clk);
    a = 32'h1; b = 32'h2; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;                 // cycle 1
    repeat (3) @(negedge clk);                    // cycle 4
    rst = 1'b1;
    @(negedge clk);                               // cycle 5
    total++; if ({busy, done, sum, cout, ovf} !== 35'h0) $display("FAIL abort_state got %b/%b/%h/%b/%b want 0/0/00000000/0/0", busy, done, sum, cout, ovf); else pass++;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done || busy) seen++; end
    total++; if (seen !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", seen); else pass++;
    do_op(32'd3, 32'd4, 1'b0, 1'b0, lat, nb);
    total++; if ({lat, sum} !== {32'd9, 32'd7}) $display("FAIL abort_recover got lat %0d sum %h want 9/00000007", lat, sum); else pass++;
    @(negedge clk);
  endtask

  task automatic test_ndig1();
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;                // cycle 1
    total++; if ({busy8, done8} !== 2'b10) $display("FAIL ndig1_busy got %b want 10", {busy8, done8}); else pass++;
    @(negedge clk);                               // cycle 2
    total++; if ({busy8, done8} !== 2'b01) $display("FAIL ndig1_done got %b want 01", {busy8, done8}); else pass++;
    total++; if ({sum8, cout8, ovf8} !== {8'h01, 1'b1, 1'b0}) $display("FAIL ndig1_result got %h/%b/%b want 01/1/0", sum8, cout8, ovf8); else pass++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_wrap();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_reset_abort();
    test_ndig1();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
